// File: rtl/csa_seq_multiplier_pkg.sv
// Shared definitions for the carry-save sequential multiplier: FSM state
// encoding and the iteration-counter width.
package csa_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter must index every multiplier bit 0..bw-1; keep at least one bit.
    function automatic int cnt_width(input int bw);
        return (bw > 1) ? $clog2(bw) : 1;
    endfunction

endpackage

// File: rtl/csa_seq_multiplier_csa_row.sv
// One row of 3:2 compressors: W independent full adders, carries left
// unshifted so the caller decides how to realign them.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);
endmodule

module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .i_a  (x[i]),
            .i_b  (y[i]),
            .i_ci (z[i]),
            .o_s  (s[i]),
            .o_co (c[i])
        );
    end
endmodule

// File: rtl/csa_seq_multiplier.sv
// Sequential unsigned BW x BW multiplier: one partial product per cycle into
// a carry-save accumulator, then a single carry-propagate cycle.
module csa_seq_multiplier
    import csa_seq_multiplier_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BW-1:0]   a,
    input  logic [BW-1:0]   b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*BW-1:0] product,
    output logic            busy,
    output state_t          dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready within the same cycle.

    localparam int PW = 2 * BW;
    localparam int CW = cnt_width(BW);
    localparam logic [CW-1:0] LAST_CNT = CW'(BW - 1);

    state_t          r_state;
    logic [BW-1:0]   r_a;
    logic [BW-1:0]   r_b;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_s;
    logic [PW-1:0]   r_c;
    logic [PW-1:0]   r_product;

    logic [PW-1:0]   w_a_ext;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_row_s;
    logic [PW-1:0]   w_row_c;
    logic [PW-1:0]   w_sum;

    assign w_a_ext = {{BW{1'b0}}, r_a};
    assign w_pp    = r_b[r_cnt] ? (w_a_ext << r_cnt) : '0;

    csa_row #(.W(PW)) u_row (
        .x (r_s),
        .y (r_c),
        .z (w_pp),
        .s (w_row_s),
        .c (w_row_c)
    );

    // Generate/propagate ripple adder resolving the redundant S/C pair.
    always_comb begin
        logic cy;
        cy    = 1'b0;
        w_sum = '0;
        for (int i = 0; i < PW; i++) begin
            w_sum[i] = r_s[i] ^ r_c[i] ^ cy;
            cy       = (r_s[i] & r_c[i]) | ((r_s[i] ^ r_c[i]) & cy);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_s       <= '0;
            r_c       <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_s     <= '0;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_s   <= w_row_s;
                    // Carry MSB is always zero since the product fits in PW bits.
                    r_c   <= w_row_c << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    r_product <= w_sum;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == ACCUM) || (r_state == RESOLVE);
    assign product   = r_product;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Bench for csa_seq_multiplier (BW = 8): scenario tasks plus a scoreboard
// that predicts each product at operand handshake and checks it on delivery.
module tb_csa_seq_multiplier;
    import csa_seq_multiplier_pkg::*;

    localparam int BW      = 8;
    localparam int PW      = 2 * BW;
    localparam int EXP_LAT = BW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;
    state_t        dbg_state;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;

    logic [PW-1:0] exp_q[$];
    int            hs_q[$];
    logic          ov_prev = 1'b0;

    csa_seq_multiplier #(.BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: predict at handshake, check latency and value at delivery.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(PW'(a) * PW'(b));
                hs_q.push_back(cyc);
            end
            if (out_valid && !ov_prev) begin
                tests_run++;
                if (hs_q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_out_valid: out_valid=1 at cycle %0d, required no pending operation", cyc);
                end else begin
                    int lat;
                    lat = cyc - hs_q.pop_front();
                    if (lat !== EXP_LAT) begin
                        failed++;
                        $display("FAIL latency: got %0d cycles, required %0d", lat, EXP_LAT);
                    end
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_product: product=%h delivered with nothing expected", product);
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    if (product !== e) begin
                        failed++;
                        $display("FAIL sb_product: got %h, required %h", product, e);
                    end
                end
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
        cyc++;
    end

    // Caller is aligned just after a rising edge; returns likewise after the handshake edge.
    task automatic do_op(input logic [BW-1:0] ta, input logic [BW-1:0] tb_v);
        int n;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests_run++;
            failed++;
            $display("FAIL handshake_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests_run++;
            failed++;
            $display("FAIL result_timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
            hs_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #1;
        tests_run++;
        if (dbg_state !== IDLE || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            failed++;
            $display("FAIL reset_state: state=%0d out_valid=%b busy=%b product=%h, required 0/0/0/0000",
                     dbg_state, out_valid, busy, product);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        do_op(8'h0D, 8'h0B);
        wait_result();
        tests_run++;
        if (product !== 16'h008F) begin
            failed++;
            $display("FAIL basic_product: got %h, required 008f", product);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL basic_one_cycle_valid: out_valid=%b after transfer, required 0", out_valid);
        end
    endtask

    task automatic test_boundaries();
        do_op(8'hFF, 8'hFF);
        wait_result();
        tests_run++;
        if (product !== 16'hFE01) begin
            failed++;
            $display("FAIL max_product: got %h, required fe01", product);
        end
        do_op(8'h00, 8'h5A);
        wait_result();
        tests_run++;
        if (product !== 16'h0000) begin
            failed++;
            $display("FAIL zero_product: got %h, required 0000", product);
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        do_op(8'h80, 8'h02);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || product !== 16'h0100) begin
                failed++;
                $display("FAIL backpressure_hold: out_valid=%b product=%h, required 1/0100", out_valid, product);
            end
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
            failed++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b state=%0d, required 1/0/0",
                     in_ready, out_valid, dbg_state);
        end
    endtask

    task automatic test_busy_reject();
        do_op(8'h03, 8'h05);
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                failed++;
                $display("FAIL busy_reject: in_ready=%b busy=%b, required 0/1", in_ready, busy);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result();
        tests_run++;
        if (product !== 16'h000F) begin
            failed++;
            $display("FAIL busy_reject_product: got %h, required 000f", product);
        end
    endtask

    task automatic test_reset_mid_accum();
        do_op(8'hFF, 8'hFF);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        hs_q.delete();
        tests_run++;
        if (dbg_state !== IDLE || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            failed++;
            $display("FAIL async_reset: state=%0d out_valid=%b busy=%b product=%h, required 0/0/0/0000",
                     dbg_state, out_valid, busy, product);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL post_reset_in_ready: got %b, required 1", in_ready);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                failed++;
                $display("FAIL aborted_out_valid: out_valid=%b, required 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        do_op(8'h12, 8'h34);
        wait_result();
        tests_run++;
        if (product !== 16'h03A8) begin
            failed++;
            $display("FAIL post_reset_product: got %h, required 03a8", product);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 1000; i++) begin
            do_op(BW'($urandom_range(0, 255)), BW'($urandom_range(0, 255)));
            wait_result();
        end
        for (int i = 0; i < 256; i++) begin
            do_op(8'hFF, BW'(i));
            wait_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_busy_reject();
        test_reset_mid_accum();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL leftover_results: %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/csa_seq_multiplier.md
Name: csa_seq_multiplier

Overview:
- Sequential unsigned BW x BW multiplier for the float_MAC mantissa path.
- Adds one shifted partial product per cycle into a carry-save accumulator built from a 3:2 compressor row. Carries are not propagated between rows.
- One final carry-propagate cycle converts the redundant sum/carry pair into a binary 2*BW product.
- Producer side takes operands through a valid/ready handshake; consumer side returns the product through a second valid/ready handshake.

Parameters:
BW, 8, operand width in bits; product width is 2*BW; BW >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b present
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  BW  multiplicand, unsigned
b  input  BW  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*BW  a*b, unsigned
busy  output  1  high in ACCUM or RESOLVE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; S, C, A_reg, B_reg, cnt, product all 0.
  - in_ready = 1 once rst_n is high; out_valid = 0; busy = 0.
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: A_reg <= a, B_reg <= b, S <= 0, C <= 0, cnt <= 0; go to ACCUM.
- ACCUM, one iteration per cycle, cnt = 0..BW-1:
  - pp = B_reg[cnt] ? (A_reg << cnt) : 0, zero-extended to 2*BW.
  - Bitwise 3:2 compression: S <= S ^ C ^ pp; C <= maj(S, C, pp) << 1, truncated to 2*BW bits. The dropped MSB is provably zero because the product fits in 2*BW bits.
  - cnt increments each cycle. When cnt == BW-1, go to RESOLVE.
  - Zero multiplier bits still take a cycle; there is no early termination.
- RESOLVE, 1 cycle:
  - product <= S + C, ripple/generate-propagate adder, result mod 2^(2*BW); go to DONE.
- DONE:
  - out_valid = 1; product held stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - If out_ready is high on entry, the transfer completes in that first DONE cycle.
- Latency: operand handshake at cycle T gives out_valid at cycle T+BW+2. Throughput is one product per BW+3 cycles minimum.
- in_valid while not IDLE: ignored, in_ready = 0, operands not latched. The producer must hold its operands until in_ready is high.
- out_ready while not DONE: no effect.
- Reset mid-operation (any state): immediate abort to IDLE; the partial result is discarded and out_valid is never asserted for that operation.
- Boundaries:
  - a = 0 or b = 0 gives product 0 with the same latency.
  - Max operands (2^BW-1)^2 must not overflow 2*BW bits.
- product retains its last value after leaving DONE until the next RESOLVE.

Decomposition:
- Shared include file holds:
  - state encoding localparams: IDLE = 2'd0, ACCUM = 2'd1, RESOLVE = 2'd2, DONE = 2'd3;
  - the counter width expression clog2(BW).
- Sub-module csa_row #(W): a W-bit array of full_adder instances, inputs x, y, z, outputs s, c (unshifted). The top applies the <<1 and truncation.
- The final S + C adder reuses the team's existing generate/propagate ripple adder, not a new module.

Test Plan (BW = 8):
- Reset, then a = 0x0D, b = 0x0B, in_valid held for one cycle, out_ready = 1 → out_valid exactly 10 cycles after the handshake; product = 0x008F; out_valid high for 1 cycle.
- a = 0xFF, b = 0xFF → product = 0xFE01, no overflow. Then a = 0x00, b = 0x5A → product = 0x0000 with the same 10-cycle latency.
- Back-pressure: a = 0x80, b = 0x02, out_ready = 0 for 5 cycles in DONE → out_valid and product = 0x0100 stay stable. When out_ready rises, the next cycle is IDLE with in_ready = 1.
- Busy rejection: accept a = 0x03, b = 0x05; during ACCUM drive in_valid with a = 0xAA, b = 0xAA → in_ready = 0, product = 0x000F, second pair never latched.
- Reset mid-ACCUM: assert rst_n = 0 at cnt = 4 → outputs take reset values asynchronously. After release, in_ready = 1, out_valid never pulses, and the next operation a = 0x12, b = 0x34 gives 0x03A8.
- Random sweep of 1000 pairs plus all 256 values of b with a = 0xFF → product == a*b every time; latency is always 10 cycles.
